// File: rtl/gf180mcu_fd_sc_mcu9t5v0__sdffrnq_2_pkg.sv
// Purpose : shared helpers for the sdffrnq/dffrnq cell family (supply check, scan-mux X-merge).
// Latency : combinational helpers only.
// Backpressure : none; library cell helpers carry no flow control.
package gf180mcu_fd_sc_mcu9t5v0__sdffrnq_2_pkg;

    localparam logic SUPPLY_HI = 1'b1;
    localparam logic SUPPLY_LO = 1'b0;

    // Supplies are good only when VDD is a clean 1 and VSS a clean 0; X or Z on either rail is bad.
    function automatic logic supply_ok(input logic vdd, input logic vss);
        return (vdd === SUPPLY_HI) && (vss === SUPPLY_LO);
    endfunction

    // Scan mux with X-merge: an unknown select still yields a known value when both legs agree.
    function automatic logic xmerge(input logic se, input logic d, input logic si);
        logic y;
        if (se === 1'b0) begin
            y = d;
        end else if (se === 1'b1) begin
            y = si;
        end else if ((d === si) && ((d === 1'b0) || (d === 1'b1))) begin
            y = d;
        end else begin
            y = 1'bx;
        end
        return y;
    endfunction

endpackage

`ifndef GF180_SUPPLY_OK
// Expands in any scope that imports the cell package.
`define GF180_SUPPLY_OK(vdd, vss) supply_ok((vdd), (vss))
`endif

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__sdffrnq_2_prims.sv
// Purpose : primitives shared by every dffrnq/sdffrnq drive strength (scan mux, async-low-reset flop).
// Latency : mux is combinational; flop updates on the rising clock edge.
// Backpressure : none.
//
// udp_mux2_xmerge ports: se (scan enable), d (functional data), si (scan data), y (selected data)
// udp_dff_rn ports     : clk, rn (async reset, active low), d, pg (power good), q
module gf180mcu_fd_sc_mcu9t5v0__udp_mux2_xmerge (
    input  logic se,
    input  logic d,
    input  logic si,
    output logic y
);
    import gf180mcu_fd_sc_mcu9t5v0__sdffrnq_2_pkg::*;

    assign y = xmerge(se, d, si);

endmodule

module gf180mcu_fd_sc_mcu9t5v0__udp_dff_rn (
    input  logic clk,
    input  logic rn,
    input  logic d,
    input  logic pg,
    output logic q
);
    // Previous levels of clk and rn. They update by non-blocking assignment, so the
    // capture block below still sees the value from before the current timestep's change.
    // That is what lets a reset release coinciding with a clock rise still count as reset,
    // and what separates a clean 0->1 edge from an X->1 edge.
    logic clk_prev;
    logic rn_prev;

    always_ff @(posedge clk or negedge clk) begin
        clk_prev <= clk;
    end

    always_ff @(posedge rn or negedge rn) begin
        rn_prev <= rn;
    end

    always_ff @(posedge clk or negedge rn or negedge pg) begin
        if (pg !== 1'b1) begin
            // Lost supply corrupts the stored state; only reset or a clean capture recovers it.
            q <= 1'bx;
        end else if (rn === 1'b0) begin
            q <= 1'b0;
        end else if ((rn !== 1'b1) || (rn_prev !== 1'b1)) begin
            // Unknown reset, or a release in this same timestep: a stored 0 is safe, anything else is not.
            q <= (q === 1'b0) ? 1'b0 : 1'bx;
        end else if ((clk_prev === 1'b0) && (clk === 1'b1)) begin
            q <= d;
        end else begin
            // Ambiguous edge (0->X, X->1): only harmless when the capture would not change q.
            q <= (d === q) ? q : 1'bx;
        end
    end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__sdffrnq_2.sv
// Purpose : muxed-scan D flip-flop, async active-low reset, drive 2, 9-track 5 V, power-pin model.
// Latency : one CLK rising edge from D/SI to Q; RN low clears Q immediately.
// Backpressure : none; Q is always driven (0, 1 or X, never Z).
//
// Ports: CLK rising-edge clock; RN async reset (low clears Q); D functional data;
//        SE scan enable (1 selects SI); SI scan data; Q registered output; VDD/VSS supplies.
module gf180mcu_fd_sc_mcu9t5v0__sdffrnq_2 (
    input  logic CLK,
    input  logic RN,
    input  logic D,
    input  logic SE,
    input  logic SI,
    output logic Q,
    inout  wire  VDD,
    inout  wire  VSS
);
    import gf180mcu_fd_sc_mcu9t5v0__sdffrnq_2_pkg::*;

    logic pg;
    logic mux_dat;
    logic q_int;

    assign pg = `GF180_SUPPLY_OK(VDD, VSS);

    gf180mcu_fd_sc_mcu9t5v0__udp_mux2_xmerge u_mux (
        .se (SE),
        .d  (D),
        .si (SI),
        .y  (mux_dat)
    );

    gf180mcu_fd_sc_mcu9t5v0__udp_dff_rn u_dff (
        .clk (CLK),
        .rn  (RN),
        .d   (mux_dat),
        .pg  (pg),
        .q   (q_int)
    );

    // Output buffer stage: reports X whenever the supplies are bad.
    assign Q = (pg === 1'b1) ? q_int : 1'bx;

endmodule
